reloj_div: RTL and testbench
============================

// Module: reloj_div
// PURPOSE
// - Synthesizable clock generator/divider for the USB-PD Rx/Tx test harness.
// - Derives a 50%-duty divided clock (clk_out) from system CLK with a runtime half-period.
// - Also provides single-cycle edge ticks and a period counter for probes and state machines.
// - Used in place of behavioural clock sources wherever a derived, resettable clock is needed.
// PARAMETERS
// - CNT_W   8   width of div_half and of the internal half-period counter
// - CYC_W   16  width of cycle_count
// - DEF_HALF 1  half-period (in CLK cycles) used when div_half==0
// PORTS
// - CLK          in   1      system clock; all logic on rising edge
// - reset        in   1      asynchronous, active-low reset (0 = in reset)
// - enable       in   1      1 = run divider; 0 = park clk_out low after current period
// - div_half     in   CNT_W  half-period length in CLK cycles (0 -> DEF_HALF)
// - clk_out      out  1      divided clock, registered, 50% duty
// - tick_rise    out  1      1-CLK pulse in the cycle clk_out goes 0->1
// - tick_fall    out  1      1-CLK pulse in the cycle clk_out goes 1->0
// - cycle_count  out  CYC_W  number of clk_out rising edges since reset
// - running      out  1      1 while divider is active (not parked)
// BEHAVIOUR
// - reset low (async): clk_out=0, tick_rise=0, tick_fall=0, cycle_count=0, running=0,
//   half counter=0, latched half = (div_half==0 ? DEF_HALF : div_half).
// - Latched half H: sampled from div_half only at reset release and on each clk_out 1->0
//   toggle (period boundary); mid-period div_half changes never shorten/stretch a phase.
// - States: PARKED (clk_out=0, counter=0) and RUN. After reset -> PARKED.
// - PARKED -> RUN when enable=1 at a CLK edge; RUN is entered with counter counting that edge.
// - RUN: counter increments each CLK edge; when counter==H-1: clk_out toggles, counter<=0.
// - So with enable=1 from reset release, first clk_out rise occurs on the H-th CLK edge;
//   clk_out period = 2*H CLK cycles; H=1 gives CLK/2.
// - tick_rise/tick_fall are registered, asserted in the same cycle clk_out changes, else 0.
// - cycle_count += 1 on every 0->1 toggle; wraps 2^CYC_W-1 -> 0 silently.
// - enable=0 while RUN: finish current period; at the 1->0 toggle go PARKED (no further rise).
//   enable=0 while clk_out=0 in RUN: go PARKED immediately at next edge, counter cleared.
// - enable re-asserted during the trailing high phase: no park, continue normally.
// - running = 1 in RUN, 0 in PARKED; updates same edge as state.
// - reset asserted mid-period: all outputs clear immediately (async), no partial pulse kept.
// - No combinational path from inputs to outputs; all outputs flop-driven (glitch-free).
// STRUCTURE
// - Shared package: state enum {PARKED, RUN}, DEF_HALF default constant.
// - Single module, no sub-modules; half-counter + toggle flop + state flop + cycle counter.
// TESTING
// - reset=0 for 4 time units, enable=1, div_half=1 -> all outputs 0 while in reset.
// - Release reset, div_half=1 -> clk_out rises on 1st CLK edge, period 2 CLK, tick_rise
//   each 2nd cycle, cycle_count=5 after 10 CLK edges.
// - div_half=3 -> high 3 cycles, low 3 cycles; change to 5 mid-high: current period stays 6,
//   next period 10.
// - enable 1->0 mid-high: clk_out completes high phase, falls, stays 0; running=0; tick_fall once.
// - Preload cycle_count near max (run 2^CYC_W rises, or CYC_W=4): 15 -> 0 on next rise.
// - Assert reset mid-high-phase -> clk_out, ticks, cycle_count go 0 without waiting for CLK.

Source files
------------

// File: rtl/reloj_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reloj_div_pkg
// Description : Shared state encoding and defaults for the reloj_div divider.
// Revision    : 1.0 - initial release
// ============================================================================
package reloj_div_pkg;

    typedef logic [0:0] state_t;

    localparam state_t c_st_parked = 1'b0;
    localparam state_t c_st_run    = 1'b1;

    // Half-period used when div_half is programmed to zero; must be >= 1.
    localparam int c_def_half = 1;

endpackage : reloj_div_pkg
`default_nettype wire

// File: rtl/reloj_div.sv
`default_nettype none
// ============================================================================
// Module      : reloj_div
// Description : Resettable 50%-duty clock divider with runtime half-period,
//               registered edge ticks, rise counter and running flag.
// Revision    : 1.0 - initial release
// ============================================================================
module reloj_div
    import reloj_div_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int CYC_W    = 16,
    parameter int DEF_HALF = c_def_half
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             enable,
    input  logic [CNT_W-1:0] div_half,
    output logic             clk_out,
    output logic             tick_rise,
    output logic             tick_fall,
    output logic [CYC_W-1:0] cycle_count,
    output logic             running
);

    localparam logic [CNT_W-1:0] c_def_half_w = CNT_W'(DEF_HALF);
    localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);
    localparam logic [CYC_W-1:0] c_cyc_one    = CYC_W'(1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_half;
    logic             r_first;
    logic             r_clk;
    logic             r_tick_rise;
    logic             r_tick_fall;
    logic [CYC_W-1:0] r_cyc;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_half_nxt;
    logic             w_clk_nxt;
    logic             w_rise;
    logic             w_fall;
    logic             w_go;
    logic [CNT_W-1:0] w_div_eff;
    logic [CNT_W-1:0] w_half;
    logic [CNT_W-1:0] w_cur;
    logic             w_hit;

    assign w_div_eff = (div_half == '0) ? c_def_half_w : div_half;
    // The first edge after reset release uses div_half directly and latches it,
    // so the reset path never has to load a value from an input pin.
    assign w_half    = r_first ? w_div_eff : r_half;
    // Entering RUN counts the entering edge as count 0.
    assign w_cur     = (r_state == c_st_run) ? r_cnt : '0;
    assign w_hit     = (w_cur == (w_half - c_cnt_one));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_half_nxt  = w_half;
        w_clk_nxt   = r_clk;
        w_rise      = 1'b0;
        w_fall      = 1'b0;
        w_go        = 1'b0;

        case (r_state)
            c_st_parked: begin
                w_cnt_nxt = '0;
                if (enable) begin
                    w_state_nxt = c_st_run;
                    w_go        = 1'b1;
                end
            end
            c_st_run: begin
                // Low phase with enable dropped: park at once, nothing to finish.
                if (!r_clk && !enable) begin
                    w_state_nxt = c_st_parked;
                    w_cnt_nxt   = '0;
                end else begin
                    w_go = 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_st_parked;
                w_cnt_nxt   = '0;
            end
        endcase

        if (w_go) begin
            if (w_hit) begin
                w_cnt_nxt = '0;
                w_clk_nxt = ~r_clk;
                if (!r_clk) begin
                    w_rise = 1'b1;
                end else begin
                    w_fall     = 1'b1;
                    w_half_nxt = w_div_eff;
                    if (!enable) begin
                        w_state_nxt = c_st_parked;
                    end
                end
            end else begin
                w_cnt_nxt = w_cur + c_cnt_one;
            end
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_state     <= c_st_parked;
            r_cnt       <= '0;
            r_half      <= c_def_half_w;
            r_first     <= 1'b1;
            r_clk       <= 1'b0;
            r_tick_rise <= 1'b0;
            r_tick_fall <= 1'b0;
            r_cyc       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_half      <= w_half_nxt;
            r_first     <= 1'b0;
            r_clk       <= w_clk_nxt;
            r_tick_rise <= w_rise;
            r_tick_fall <= w_fall;
            if (w_rise) begin
                r_cyc <= r_cyc + c_cyc_one;
            end
        end
    end

    assign clk_out     = r_clk;
    assign tick_rise   = r_tick_rise;
    assign tick_fall   = r_tick_fall;
    assign cycle_count = r_cyc;
    assign running     = (r_state == c_st_run);

endmodule : reloj_div
`default_nettype wire

// File: tb/tb_reloj_div.sv
`default_nettype none
// ============================================================================
// Module      : tb_reloj_div
// Description : Scoreboard bench for reloj_div against an edge-deadline model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reloj_div;
    import reloj_div_pkg::*;

    localparam int CNT_W    = 8;
    localparam int CYC_W    = 4;
    localparam int DEF_HALF = 2;

    logic             CLK = 1'b0;
    logic             reset = 1'b1;
    logic             enable = 1'b0;
    logic [CNT_W-1:0] div_half = '0;
    logic             clk_out;
    logic             tick_rise;
    logic             tick_fall;
    logic [CYC_W-1:0] cycle_count;
    logic             running;

    reloj_div #(
        .CNT_W    (CNT_W),
        .CYC_W    (CYC_W),
        .DEF_HALF (DEF_HALF)
    ) dut (
        .CLK         (CLK),
        .reset       (reset),
        .enable      (enable),
        .div_half    (div_half),
        .clk_out     (clk_out),
        .tick_rise   (tick_rise),
        .tick_fall   (tick_fall),
        .cycle_count (cycle_count),
        .running     (running)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit is_rise;
        int edge_n;
        int count;
        bit run;
    } ev_t;

    ev_t exp_q[$];
    int  fall_edges[$];
    int  checks = 0;
    int  failures = 0;
    int  mon_edge = 0;
    int  n_rise = 0;
    int  n_fall = 0;
    bit  rel_pending = 0;

    // Reference model: phase deadlines expressed in absolute edge numbers.
    bit m_run, m_level, m_first;
    int m_h, m_dead, m_count;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int eff(input int dh);
        return (dh == 0) ? DEF_HALF : dh;
    endfunction

    task automatic model_step(input bit en, input int dh);
        int  n = mon_edge + 1;
        ev_t e;
        if (m_first) begin
            m_h     = eff(dh);
            m_first = 0;
        end
        if (!m_run) begin
            if (!en) return;
            m_run   = 1;
            m_level = 0;
            m_dead  = n + m_h - 1;
        end else if (!m_level && !en) begin
            m_run = 0;
            return;
        end
        if (n == m_dead) begin
            if (!m_level) begin
                m_level   = 1;
                m_count   = (m_count + 1) % (1 << CYC_W);
                e.is_rise = 1; e.edge_n = n; e.count = m_count; e.run = 1;
                exp_q.push_back(e);
                m_dead    = n + m_h;
            end else begin
                m_level   = 0;
                m_h       = eff(dh);
                e.is_rise = 0; e.edge_n = n; e.count = m_count; e.run = en;
                exp_q.push_back(e);
                if (!en) m_run = 0;
                else     m_dead = n + m_h;
            end
        end
    endtask

    task automatic step(input bit en, input int dh);
        @(negedge CLK);
        if (rel_pending) begin
            reset       = 1'b1;
            rel_pending = 0;
        end
        enable   = en;
        div_half = CNT_W'(dh);
        model_step(en, dh);
    endtask

    task automatic do_reset(input bit en, input int dh);
        reset    = 1'b0;
        enable   = en;
        div_half = CNT_W'(dh);
        exp_q.delete();
        fall_edges.delete();
        n_rise  = 0;
        n_fall  = 0;
        m_run   = 0;
        m_level = 0;
        m_first = 1;
        m_count = 0;
        m_h     = eff(dh);
        m_dead  = 0;
        repeat (2) @(negedge CLK);
        rel_pending = 1;
    endtask

    always @(posedge CLK) begin
        if (!reset) mon_edge = 0;
        else        mon_edge++;
    end

    // Monitor: every tick must match the oldest expected edge event.
    always @(negedge CLK) begin
        ev_t e;
        if (reset) begin
            while (exp_q.size() > 0 && exp_q[0].edge_n < mon_edge) begin
                check("missed_event_edge", mon_edge, exp_q[0].edge_n);
                void'(exp_q.pop_front());
            end
            if (tick_rise || tick_fall) begin
                n_rise += int'(tick_rise);
                n_fall += int'(tick_fall);
                if (tick_fall) fall_edges.push_back(mon_edge);
                if (exp_q.size() == 0 || exp_q[0].edge_n != mon_edge) begin
                    check("unexpected_tick_edge", mon_edge, (exp_q.size() == 0) ? -1 : exp_q[0].edge_n);
                end else begin
                    e = exp_q.pop_front();
                    check("event_rise_fall_clk_run_count",
                          {tick_rise, tick_fall, clk_out, running, 4'(cycle_count)},
                          {e.is_rise, ~e.is_rise, e.is_rise, e.run, 4'(e.count)});
                end
            end
        end
    end

    initial begin
        int dh_r;
        bit en_r;

        // Reset behaviour with no clock edge involved.
        #1 reset = 1'b0;
        enable   = 1'b1;
        div_half = 8'd1;
        #3;
        check("reset_clk_out", clk_out, 0);
        check("reset_tick_rise", tick_rise, 0);
        check("reset_tick_fall", tick_fall, 0);
        check("reset_cycle_count", cycle_count, 0);
        check("reset_running", running, 0);

        // H=1: CLK/2, five rises in ten edges.
        do_reset(1, 1);
        repeat (11) step(1, 1);
        check("h1_count_after_10", cycle_count, 5);
        check("h1_clk_after_10", clk_out, 0);

        // H=3 then 5 written mid-high: fall-to-fall 6 then 10.
        do_reset(1, 3);
        for (int i = 1; i <= 18; i++) step(1, (i <= 3) ? 3 : 5);
        if (fall_edges.size() < 2) begin
            check("h35_fall_count", fall_edges.size(), 2);
        end else begin
            check("h35_first_period", fall_edges[0], 6);
            check("h35_second_period", fall_edges[1] - fall_edges[0], 10);
        end

        // enable dropped mid-high: one fall, then parked.
        do_reset(1, 2);
        for (int i = 1; i <= 13; i++) step(i <= 2, 2);
        check("park_hi_falls", n_fall, 1);
        check("park_hi_rises", n_rise, 1);
        check("park_hi_clk", clk_out, 0);
        check("park_hi_running", running, 0);

        // enable dropped in low phase: parks at the next edge.
        do_reset(1, 3);
        step(1, 3);
        step(0, 3);
        step(1, 3);
        check("park_lo_running", running, 0);
        check("park_lo_clk", clk_out, 0);
        repeat (6) step(1, 3);
        check("park_lo_rerun", running, 1);

        // Rise counter wrap with CYC_W=4.
        do_reset(1, 1);
        for (int i = 1; i <= 32; i++) begin
            step(1, 1);
            if (i == 30) check("wrap_count_15", cycle_count, 15);
            if (i == 32) check("wrap_count_0", cycle_count, 0);
        end

        // Asynchronous reset in the middle of the cycle that raised clk_out.
        do_reset(1, 4);
        repeat (4) step(1, 4);
        @(posedge CLK);
        #2;
        check("async_pre_tick_rise", tick_rise, 1);
        reset = 1'b0;
        #1;
        check("async_clk_out", clk_out, 0);
        check("async_tick_rise", tick_rise, 0);
        check("async_tick_fall", tick_fall, 0);
        check("async_cycle_count", cycle_count, 0);
        check("async_running", running, 0);

        // Randomized run against the model.
        dh_r = $urandom_range(0, 6);
        en_r = 1;
        do_reset(en_r, dh_r);
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) dh_r = $urandom_range(0, 6);
            if ($urandom_range(0, 9) == 0) en_r = !en_r;
            if ($urandom_range(0, 499) == 0) begin
                @(negedge CLK);
                #2;
                do_reset(en_r, dh_r);
            end
            step(en_r, dh_r);
        end
        repeat (30) step(0, dh_r);
        @(negedge CLK);
        #1;
        check("drain_queue_empty", exp_q.size(), 0);
        check("drain_clk_out", clk_out, 0);
        check("drain_running", running, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_reloj_div
`default_nettype wire
